// File: rtl/ram_access_ctrl_pkg.sv
// Shared encodings and lane/size helpers for the byte-addressed RAM front end.
package ram_access_ctrl_pkg;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_BYTE = 2'b01,
    WR_HALF = 2'b10,
    WR_WORD = 2'b11
  } write_type_e;

  typedef enum logic [2:0] {
    RD_NONE  = 3'b000,
    RD_BYTE  = 3'b001,
    RD_HALF  = 3'b010,
    RD_WORD  = 3'b011,
    RD_SBYTE = 3'b101,
    RD_SHALF = 3'b110
  } read_type_e;

  typedef enum logic {
    ST_IDLE,
    ST_SECOND
  } state_e;

  // The reserved encodings 100 and 111 collapse to "no read".
  function automatic read_type_e norm_read(input logic [2:0] t);
    case (t)
      3'b001:  return RD_BYTE;
      3'b010:  return RD_HALF;
      3'b011:  return RD_WORD;
      3'b101:  return RD_SBYTE;
      3'b110:  return RD_SHALF;
      default: return RD_NONE;
    endcase
  endfunction

  // A no-op reports size 1 so it can never span a word boundary.
  function automatic logic [2:0] size_from_type(input write_type_e wt, input read_type_e rt);
    if (wt != WR_NONE) begin
      case (wt)
        WR_BYTE: return 3'd1;
        WR_HALF: return 3'd2;
        default: return 3'd4;
      endcase
    end
    case (rt)
      RD_HALF, RD_SHALF: return 3'd2;
      RD_WORD:           return 3'd4;
      default:           return 3'd1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [2:0] n);
    logic [7:0] m;
    m = ((8'd1 << n) - 8'd1) << off;
    return m[3:0];
  endfunction

  function automatic logic spans(input logic [1:0] off, input logic [2:0] n);
    return ({2'b00, off} + {1'b0, n}) > 4'd4;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input read_type_e rt);
    case (rt)
      RD_BYTE:  return {24'd0, v[7:0]};
      RD_HALF:  return {16'd0, v[15:0]};
      RD_SBYTE: return {{24{v[7]}}, v[7:0]};
      RD_SHALF: return {{16{v[15]}}, v[15:0]};
      default:  return v;
    endcase
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request/response and RAM-side signals of the load/store front end.
interface ram_access_ctrl_if #(
  parameter int ADDRESS_BITWIDTH = 16
);
  logic                        req_valid;
  logic                        req_ready;
  logic [ADDRESS_BITWIDTH-1:0] address;
  logic [1:0]                  write_type;
  logic [2:0]                  read_type;
  logic [31:0]                 data_in;
  logic                        resp_valid;
  logic [31:0]                 data_out;
  logic [ADDRESS_BITWIDTH-3:0] ram_address;
  logic [3:0]                  ram_write_enable;
  logic [31:0]                 ram_data_in;
  logic [31:0]                 ram_data_out;

  modport slave (
    input  req_valid, address, write_type, read_type, data_in, ram_data_out,
    output req_ready, resp_valid, data_out, ram_address, ram_write_enable, ram_data_in
  );

  modport master (
    output req_valid, address, write_type, read_type, data_in, ram_data_out,
    input  req_ready, resp_valid, data_out, ram_address, ram_write_enable, ram_data_in
  );
endinterface

// File: rtl/ram_access_align.sv
// Lane alignment for one RAM cycle: write mask/data shifting and read merge/extension.
module ram_access_align
  import ram_access_ctrl_pkg::*;
(
  input  logic        second_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  input  read_type_e  rtype_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] rlow_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rlow_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  lo_sh;
  logic [5:0]  hi_sh;
  logic [3:0]  end_lane;
  logic [7:0]  hi_mask;
  logic [31:0] merged;

  always_comb begin
    lo_sh    = {off_i, 3'b000};
    hi_sh    = {3'd4 - {1'b0, off_i}, 3'b000};
    // Only meaningful for spanning accesses, where it is 1..3.
    end_lane = {2'b00, off_i} + {1'b0, size_i} - 4'd4;
    hi_mask  = (8'd1 << end_lane) - 8'd1;
    rlow_o   = rword_i >> lo_sh;
    wmask_o  = lane_mask(off_i, size_i);
    wdata_o  = wdata_i << lo_sh;
    merged   = rlow_o;
    if (second_i) begin
      wmask_o = hi_mask[3:0];
      wdata_o = wdata_i >> hi_sh;
      merged  = rlow_i | (rword_i << hi_sh);
    end
    rdata_o = extend(merged, rtype_i);
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Byte-addressed load/store front end; splits word-crossing accesses into two RAM cycles.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH = 16,
  parameter int DATA_BITWIDTH    = 32,
  parameter int COLUMN_BITWIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_access_ctrl_if.slave  bus
);

  localparam int WA    = ADDRESS_BITWIDTH - 2;
  localparam int LANES = DATA_BITWIDTH / COLUMN_BITWIDTH;

  state_e      state_q, state_d;
  logic [WA-1:0] waddr_q, waddr_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  size_q, size_d;
  logic        wr_q, wr_d;
  read_type_e  rtype_q, rtype_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rlow_q, rlow_d;
  logic [31:0] data_out_q, data_out_d;
  logic        resp_q, resp_d;

  write_type_e req_wt;
  read_type_e  req_rt;
  logic [2:0]  req_size;
  logic        req_wr, accept, second;

  logic [1:0]       a_off;
  logic [2:0]       a_size;
  read_type_e       a_rtype;
  logic [31:0]      a_wdata;
  logic [LANES-1:0] wmask;
  logic [31:0]      wdata_sh, rlow_sh, rdata_ext;

  logic [LANES-1:0] ram_we;
  logic [WA-1:0]    ram_addr;

  // A request carrying both a write and a read is handled as a write only.
  assign req_wt   = write_type_e'(bus.write_type);
  assign req_wr   = (req_wt != WR_NONE);
  assign req_rt   = req_wr ? RD_NONE : norm_read(bus.read_type);
  assign req_size = size_from_type(req_wt, req_rt);
  assign second   = (state_q == ST_SECOND);
  assign accept   = bus.req_valid && (state_q == ST_IDLE);

  assign a_off   = second ? off_q   : bus.address[1:0];
  assign a_size  = second ? size_q  : req_size;
  assign a_rtype = second ? rtype_q : req_rt;
  assign a_wdata = second ? wdata_q : bus.data_in;

  ram_access_align u_align (
    .second_i (second),
    .off_i    (a_off),
    .size_i   (a_size),
    .rtype_i  (a_rtype),
    .wdata_i  (a_wdata),
    .rword_i  (bus.ram_data_out),
    .rlow_i   (rlow_q),
    .wmask_o  (wmask),
    .wdata_o  (wdata_sh),
    .rlow_o   (rlow_sh),
    .rdata_o  (rdata_ext)
  );

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    off_d      = off_q;
    size_d     = size_q;
    wr_d       = wr_q;
    rtype_d    = rtype_q;
    wdata_d    = wdata_q;
    rlow_d     = rlow_q;
    data_out_d = data_out_q;
    resp_d     = 1'b0;
    ram_we     = '0;
    ram_addr   = bus.address[ADDRESS_BITWIDTH-1:2];
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_wr) ram_we = wmask;
          if (spans(bus.address[1:0], req_size)) begin
            waddr_d = bus.address[ADDRESS_BITWIDTH-1:2];
            off_d   = bus.address[1:0];
            size_d  = req_size;
            wr_d    = req_wr;
            rtype_d = req_rt;
            wdata_d = bus.data_in;
            rlow_d  = rlow_sh;
            state_d = ST_SECOND;
          end else begin
            resp_d = 1'b1;
            if (req_rt != RD_NONE) data_out_d = rdata_ext;
          end
        end
      end
      ST_SECOND: begin
        ram_addr = waddr_q + WA'(1);
        if (wr_q) ram_we = wmask;
        if (rtype_q != RD_NONE) data_out_d = rdata_ext;
        resp_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Keep the RAM untouched for as long as reset is held.
    if (!rst_n) ram_we = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      waddr_q    <= '0;
      off_q      <= '0;
      size_q     <= '0;
      wr_q       <= 1'b0;
      rtype_q    <= RD_NONE;
      wdata_q    <= '0;
      rlow_q     <= '0;
      data_out_q <= '0;
      resp_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      off_q      <= off_d;
      size_q     <= size_d;
      wr_q       <= wr_d;
      rtype_q    <= rtype_d;
      wdata_q    <= wdata_d;
      rlow_q     <= rlow_d;
      data_out_q <= data_out_d;
      resp_q     <= resp_d;
    end
  end

  assign bus.req_ready        = (state_q == ST_IDLE);
  assign bus.resp_valid       = resp_q;
  assign bus.data_out         = data_out_q;
  assign bus.ram_address      = ram_addr;
  assign bus.ram_write_enable = ram_we;
  assign bus.ram_data_in      = wdata_sh;

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
Byte-addressed load/store front end that sits directly upstream of the byte-enabled semi-dual-port block RAM. It converts CPU-style requests (byte/half/word, signed or unsigned reads, any alignment) into word-addressed RAM cycles with per-byte write enables. Unaligned accesses that cross a word boundary are split into two RAM cycles. Read data is returned registered and extended to 32 bits.

Parameters:
ADDRESS_BITWIDTH, 16, byte address width; RAM word address width is ADDRESS_BITWIDTH-2
DATA_BITWIDTH, 32, RAM word width; fixed at 32, other values unsupported
COLUMN_BITWIDTH, 8, byte-lane width; fixed at 8

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
address  in  ADDRESS_BITWIDTH  byte address
write_type  in  2  00 none, 01 byte, 10 half, 11 word
read_type  in  3  000 none, 001 byte, 010 half, 011 word, 101 signed byte, 110 signed half
data_in  in  32  store data, right-aligned
resp_valid  out  1  one-cycle pulse: operation complete; data_out valid for reads
data_out  out  32  load data, zero- or sign-extended
ram_address  out  ADDRESS_BITWIDTH-2  RAM word address
ram_write_enable  out  4  RAM byte-lane enables, bit i = bits [8i+7:8i]
ram_data_in  out  32  write data to RAM, lane-shifted
ram_data_out  in  32  RAM combinational read data at ram_address

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, resp_valid=0, data_out=0, latched regs=0.
- ram_write_enable is forced to 0 whenever rst_n=0, combinationally, so no RAM writes occur during reset.
- Little-endian: byte at address A is in lane A[1:0] of word A>>2.
- Size n = 1/2/4 bytes; off = address[1:0]; the access spans two words iff off+n > 4.
- Accept condition: req_valid && req_ready. req_ready = (state==IDLE).
- A request with write_type=00 and read_type=000 is accepted and produces resp_valid, with data_out unchanged.
- A request with both write_type and read_type nonzero is treated as a write only; data_out is unchanged.
- States: IDLE, SECOND.
- IDLE, accepted request:
  - ram_address = address[ADDR-1:2].
  - Write: ram_data_in = data_in << (8*off); ram_write_enable = first-word lane mask ((1<<n)-1)<<off, truncated to 4 bits.
  - Non-spanning: next cycle resp_valid=1; for reads, data_out = extend(ram_data_out >> 8*off) is registered at the accept edge. Stay IDLE.
  - Spanning: latch word address, off, n, type, data_in, and the low read bytes; go to SECOND.
- IDLE, no accepted request: ram_write_enable = 0; ram_address = address[ADDR-1:2] (don't-care).
- SECOND:
  - ram_address = latched word address + 1, wrapping modulo 2^(ADDR-2); top word wraps to 0.
  - Write: ram_write_enable = (1<<(off+n-4))-1; ram_data_in = latched data_in >> 8*(4-off).
  - Read: merge ram_data_out low bytes above the latched bytes, then extend.
  - Register data_out; go IDLE; resp_valid=1 the following cycle.
- Latency: non-spanning 1 cycle from accept to resp_valid; spanning 2 cycles; throughput 1 request/cycle when non-spanning.
- Extension: signed types replicate bit 7 (byte) or bit 15 (half); unsigned types and word reads zero-fill.
- Invalid read_type (100, 111) is treated as 000.
- Reset asserted while in SECOND: the second-word write is suppressed, state returns to IDLE, no resp_valid.

Decomposition:
- Shared package holds the write_type/read_type encodings, the lane-mask function and the size-from-type function.
- One natural sub-module: ram_access_align, purely combinational. It takes off, n, type, data and produces the lane mask, shifted write data and extended read data. The FSM and registers stay in ram_access_ctrl.

Test Plan:
- Aligned word write 0x1000 <- 0xDEADBEEF, then word read 0x1000 -> ram_write_enable=1111 at word 0x400; one cycle later resp_valid, data_out=0xDEADBEEF.
- Byte write 0x1003 <- 0x000000AA, then signed byte read -> enable=1000, ram_data_in=0xAA000000; data_out=0xFFFFFFAA; unsigned byte read gives 0x000000AA.
- Unaligned half write 0x1003 <- 0x1234 -> cycle1 word 0x400 enable=1000 data 0x34xxxxxx; cycle2 word 0x401 enable=0001 data 0x12; a later half read returns 0x00001234 two cycles after accept.
- Unaligned word read at 0x1002 with words 0x400=0x44332211, 0x401=0x88776655 -> data_out=0x66554433; req_ready low during SECOND.
- Wrap: word write at 0xFFFE -> second cycle ram_address=0x0000, enable=0011.
- Reset asserted during SECOND of the 0x1003 half write -> no write to word 0x401, no resp_valid, req_ready=1 after release.
